// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_pkg: shared definitions for the register-file writeback arbiter.
//   REG_ADDR_W / REG_DATA_W : default register address and data widths
//   wb_req_t                : one writeback request {addr, data}
//   wb_src_e                : writeback source, used as the round-robin pointer
//   wb_src_other()          : the source that is not the one given
package reg_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_e;

  function automatic wb_src_e wb_src_other(input wb_src_e src);
    return (src == WB_SRC_ALU) ? WB_SRC_LD : WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_arb.sv
// rr_arb2: two-way round-robin arbiter with a last-grant register.
//   clk, reset          : clock, synchronous active-high reset
//   i_req_alu, i_req_ld : request lines (the valids)
//   o_gnt_alu, o_gnt_ld : one-hot grants (the readys); combinational
//   o_accept            : a grant was issued this cycle
// Grants are forced low while reset is high. The last-grant pointer resets
// to ALU so that the load path wins the first tie.
module rr_arb2
  import reg_wb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_alu,
  input  logic i_req_ld,
  output logic o_gnt_alu,
  output logic o_gnt_ld,
  output logic o_accept
);

  wb_src_e r_last;
  logic    w_ld_wins;

  // On a tie the pointer names the loser: whoever was granted last waits.
  always_comb begin
    w_ld_wins = i_req_ld && (!i_req_alu || (wb_src_other(r_last) == WB_SRC_LD));
    o_gnt_ld  = !reset && w_ld_wins;
    o_gnt_alu = !reset && i_req_alu && !w_ld_wins;
  end

  assign o_accept = o_gnt_alu | o_gnt_ld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= WB_SRC_ALU;
    end else if (o_accept) begin
      r_last <= o_gnt_ld ? WB_SRC_LD : WB_SRC_ALU;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register file write port between the ALU
// writeback and the load-return paths, and tracks pending destinations.
//   clk, reset                          : clock, synchronous active-high reset
//   alu_valid/alu_ready, alu_addr/data  : ALU writeback handshake and payload
//   ld_valid/ld_ready, ld_addr/data     : load-return handshake and payload
//   claim_valid, claim_addr             : issue stage reserves a destination
//   rd_addr_a, rd_addr_b                : issue-stage source registers
//   hazard                              : a source register is pending
//   rf_write, rf_write_addr, rf_data_in : registered register-file write port
//   pending                             : per-register scoreboard, bit 0 always 0
//   sb_err                              : sticky scoreboard protocol error
//   fwd_a_hit, fwd_b_hit, fwd_data      : bypass from the write port
// Build option: define REG_WB_ARBITER_BYPASS_EN to forward the in-flight
// write to the issue stage and mask its hazard; otherwise the fwd_* outputs
// are tied 0.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     claim_valid,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic                     hazard,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_write_addr,
  output logic [DATA_W-1:0]        rf_data_in,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic                     sb_err,
  output logic                     fwd_a_hit,
  output logic                     fwd_b_hit,
  output logic [DATA_W-1:0]        fwd_data
);

  localparam int NREG = 1 << ADDR_W;

  logic              w_gnt_alu;
  logic              w_gnt_ld;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_rf_write;
  logic [ADDR_W-1:0] r_rf_write_addr;
  logic [DATA_W-1:0] r_rf_data_in;

  logic [NREG-1:0]   r_pending;
  logic              r_sb_err;
  logic [NREG-1:0]   w_set_vec;
  logic [NREG-1:0]   w_clr_vec;
  logic [NREG-1:0]   w_pending_nxt;
  logic              w_claim_err;
  logic              w_write_err;

  logic              w_fwd_a;
  logic              w_fwd_b;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req_alu (alu_valid),
    .i_req_ld  (ld_valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_ld  (w_gnt_ld),
    .o_accept  (w_accept)
  );

  assign alu_ready  = w_gnt_alu;
  assign ld_ready   = w_gnt_ld;
  assign w_sel_addr = w_gnt_ld ? ld_addr : alu_addr;
  assign w_sel_data = w_gnt_ld ? ld_data : alu_data;

  // ---------------------------------------------------------------------------
  // Output register: drains every cycle, so rf_write is a one-cycle pulse.
  // Writes to register 0 are consumed without raising rf_write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_write      <= 1'b0;
      r_rf_write_addr <= '0;
      r_rf_data_in    <= '0;
    end else if (w_accept) begin
      r_rf_write      <= (w_sel_addr != '0);
      r_rf_write_addr <= w_sel_addr;
      r_rf_data_in    <= w_sel_data;
    end else begin
      r_rf_write      <= 1'b0;
    end
  end

  assign rf_write      = r_rf_write;
  assign rf_write_addr = r_rf_write_addr;
  assign rf_data_in    = r_rf_data_in;

  // ---------------------------------------------------------------------------
  // Scoreboard. The clear is applied first and the set OR'd on top, so a
  // claim and a retiring write to the same register leave it pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (claim_valid && (claim_addr != '0)) begin
      w_set_vec[claim_addr] = 1'b1;
    end
    if (r_rf_write) begin
      w_clr_vec[r_rf_write_addr] = 1'b1;
    end
    w_pending_nxt    = (r_pending & ~w_clr_vec) | w_set_vec;
    w_pending_nxt[0] = 1'b0;
  end

  assign w_claim_err = claim_valid && (claim_addr != '0) && r_pending[claim_addr];
  assign w_write_err = r_rf_write && (r_rf_write_addr != '0) && !r_pending[r_rf_write_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_sb_err  <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_sb_err  <= r_sb_err | w_claim_err | w_write_err;
    end
  end

  assign pending = r_pending;
  assign sb_err  = r_sb_err;

  // ---------------------------------------------------------------------------
  // Bypass and hazard
  // ---------------------------------------------------------------------------
`ifdef REG_WB_ARBITER_BYPASS_EN
  assign w_fwd_a  = r_rf_write && (r_rf_write_addr == rd_addr_a) && (rd_addr_a != '0);
  assign w_fwd_b  = r_rf_write && (r_rf_write_addr == rd_addr_b) && (rd_addr_b != '0);
  assign fwd_data = r_rf_data_in;
`else
  assign w_fwd_a  = 1'b0;
  assign w_fwd_b  = 1'b0;
  assign fwd_data = '0;
`endif

  assign fwd_a_hit = w_fwd_a;
  assign fwd_b_hit = w_fwd_b;

  // A source being written this cycle is satisfied by the bypass, so only
  // unforwarded pending sources stall issue.
  assign hazard = (r_pending[rd_addr_a] & ~w_fwd_a) |
                  (r_pending[rd_addr_b] & ~w_fwd_b);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;
  import reg_wb_pkg::*;

`ifdef REG_WB_ARBITER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, claim_valid;
  logic        alu_ready, ld_ready;
  logic [4:0]  alu_addr, ld_addr, claim_addr, rd_addr_a, rd_addr_b;
  logic [31:0] alu_data, ld_data;
  logic        hazard, rf_write, sb_err, fwd_a_hit, fwd_b_hit;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_data_in, pending, fwd_data;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard(hazard),
    .rf_write(rf_write), .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in),
    .pending(pending), .sb_err(sb_err),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_data(fwd_data)
  );

  typedef struct {
    logic    av;
    wb_req_t ar;
    logic    lv;
    wb_req_t lr;
    logic    cv;
    logic [4:0] ca, ra, rb;
    logic    e_ar, e_lr, e_hz, e_wr;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_pend;
    logic    e_err;
  } vec_t;

  function automatic vec_t mkvec(
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic lv, input logic [4:0] la, input logic [31:0] ldd,
    input logic cv, input logic [4:0] ca, input logic [4:0] ra, input logic [4:0] rb,
    input logic e_ar, input logic e_lr, input logic e_hz,
    input logic e_wr, input logic [4:0] e_wa, input logic [31:0] e_wd,
    input logic [31:0] e_pend, input logic e_err);
    vec_t v;
    v.av = av; v.ar.addr = aa; v.ar.data = ad;
    v.lv = lv; v.lr.addr = la; v.lr.data = ldd;
    v.cv = cv; v.ca = ca; v.ra = ra; v.rb = rb;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_hz = e_hz;
    v.e_wr = e_wr; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_pend = e_pend; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                       input logic cv, input logic [4:0] ca,
                       input logic [4:0] ra, input logic [4:0] rb);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    claim_valid = cv; claim_addr = ca; rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic idle(input logic [4:0] ra);
    drive(0, 0, 0, 0, 0, 0, 0, 0, ra, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Behavioural reference model state
  bit          m_last_alu;
  bit          m_pend [32];
  bit          m_err;
  bit          m_wr;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic model_reset();
    m_last_alu = 1'b1;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_err = 0; m_wr = 0; m_wa = '0; m_wd = '0;
  endtask

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    reset = 1'b1;
    idle(0);

    //            av aa  ad            lv la ld     cv ca ra rb  ar lr hz           wr wa wd            pend err
    tbl[0] = mkvec(0, 0, 32'h0,        0, 0, 32'h0, 1, 3, 3, 0,  0, 0, 0,           0, 0, 32'h0,        32'h0, 0);
    tbl[1] = mkvec(1, 3, 32'hDEADBEEF, 0, 0, 32'h0, 0, 0, 3, 0,  1, 0, 1,           0, 0, 32'h0,        32'h8, 0);
    tbl[2] = mkvec(0, 0, 32'h0,        0, 0, 32'h0, 0, 0, 3, 0,  0, 0, BYP ? 0 : 1, 1, 3, 32'hDEADBEEF, 32'h8, 0);
    tbl[3] = mkvec(0, 0, 32'h0,        0, 0, 32'h0, 0, 0, 3, 0,  0, 0, 0,           0, 0, 32'h0,        32'h0, 0);
    tbl[4] = mkvec(1, 4, 32'h44,       1, 5, 32'h55, 0, 0, 0, 0, 0, 1, 0,           0, 0, 32'h0,        32'h0, 0);
    tbl[5] = mkvec(1, 4, 32'h44,       1, 5, 32'h55, 0, 0, 0, 0, 1, 0, 0,           1, 5, 32'h55,       32'h0, 0);
    tbl[6] = mkvec(1, 4, 32'h44,       1, 5, 32'h55, 0, 0, 0, 0, 0, 1, 0,           1, 4, 32'h44,       32'h0, 1);
    tbl[7] = mkvec(1, 4, 32'h44,       1, 5, 32'h55, 0, 0, 0, 0, 1, 0, 0,           1, 5, 32'h55,       32'h0, 1);
    tbl[8] = mkvec(0, 0, 32'h0,        0, 0, 32'h0, 0, 0, 0, 0,  0, 0, 0,           1, 4, 32'h44,       32'h0, 1);
    tbl[9] = mkvec(0, 0, 32'h0,        0, 0, 32'h0, 0, 0, 0, 0,  0, 0, 0,           0, 0, 32'h0,        32'h0, 1);

    // ---------------- reset values ----------------
    do_reset();
    #1;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_rf_write", rf_write, 0);
    chk("rst_rf_addr", rf_write_addr, 0);
    chk("rst_rf_data", rf_data_in, 0);
    chk("rst_pending", pending, 0);
    chk("rst_sb_err", sb_err, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_fwd_a", fwd_a_hit, 0);
    chk("rst_fwd_b", fwd_b_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].av, tbl[i].ar.addr, tbl[i].ar.data, tbl[i].lv, tbl[i].lr.addr, tbl[i].lr.data,
            tbl[i].cv, tbl[i].ca, tbl[i].ra, tbl[i].rb);
      #1;
      chk($sformatf("tbl%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("tbl%0d_ld_ready", i), ld_ready, tbl[i].e_lr);
      chk($sformatf("tbl%0d_hazard", i), hazard, tbl[i].e_hz);
      chk($sformatf("tbl%0d_rf_write", i), rf_write, tbl[i].e_wr);
      if (tbl[i].e_wr) begin
        chk($sformatf("tbl%0d_rf_addr", i), rf_write_addr, tbl[i].e_wa);
        chk($sformatf("tbl%0d_rf_data", i), rf_data_in, tbl[i].e_wd);
      end
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
      chk($sformatf("tbl%0d_sb_err", i), sb_err, tbl[i].e_err);
      tick();
    end

    // ---------------- claim 7 / load retire / bypass ----------------
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0); #1;
    chk("c7_hz_c0", hazard, 0);
    tick();
    idle(7); #1;
    chk("c7_hz_c1", hazard, 1);
    chk("c7_pend_c1", pending, 32'h80);
    tick();
    #1;
    chk("c7_hz_c2", hazard, 1);
    tick();
    drive(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0); #1;
    chk("c7_ld_ready_c3", ld_ready, 1);
    chk("c7_alu_ready_c3", alu_ready, 0);
    chk("c7_hz_c3", hazard, 1);
    tick();
    idle(7); #1;
    chk("c7_wr_c4", rf_write, 1);
    chk("c7_waddr_c4", rf_write_addr, 7);
    chk("c7_wdata_c4", rf_data_in, 32'h77);
    chk("c7_hz_c4", hazard, BYP ? 0 : 1);
    chk("c7_fwd_a_c4", fwd_a_hit, BYP ? 1 : 0);
    chk("c7_fwd_b_c4", fwd_b_hit, 0);
    chk("c7_fwd_data_c4", fwd_data, BYP ? 32'h77 : 32'h0);
    tick();
    #1;
    chk("c7_hz_c5", hazard, 0);
    chk("c7_pend_c5", pending, 0);
    chk("c7_wr_c5", rf_write, 0);
    chk("c7_err_c5", sb_err, 0);

    // ---------------- write to register 0 ----------------
    do_reset();
    drive(1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("z_alu_ready", alu_ready, 1);
    tick();
    idle(0); #1;
    chk("z_rf_write", rf_write, 0);
    chk("z_pending", pending, 0);
    tick();
    #1;
    chk("z_sb_err", sb_err, 0);

    // ---------------- double claim ----------------
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); tick();
    #1;
    chk("dc_err_after_first", sb_err, 0);
    tick();
    idle(0); #1;
    chk("dc_err_after_second", sb_err, 1);
    chk("dc_pending", pending, 32'h200);

    // ---------------- write to non-pending register, sticky ----------------
    do_reset();
    drive(1, 10, 32'hA, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("np_alu_ready", alu_ready, 1);
    tick();
    idle(0); #1;
    chk("np_wr", rf_write, 1);
    chk("np_err_pre", sb_err, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("np_err_hold%0d", k), sb_err, 1);
      tick();
    end
    do_reset();
    #1;
    chk("np_err_cleared", sb_err, 0);

    // ---------------- reset during an in-flight write ----------------
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0); tick();
    drive(0, 0, 0, 1, 7, 32'h1234, 0, 0, 0, 0); #1;
    chk("rw_ld_ready", ld_ready, 1);
    tick();
    reset = 1'b1;
    drive(1, 7, 32'h5, 1, 6, 32'h6, 0, 0, 0, 0); #1;
    chk("rw_wr_inflight", rf_write, 1);
    chk("rw_pend_inflight", pending, 32'h80);
    chk("rw_alu_ready_rst", alu_ready, 0);
    chk("rw_ld_ready_rst", ld_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rw_wr_after", rf_write, 0);
    chk("rw_pend_after", pending, 0);
    chk("rw_waddr_after", rf_write_addr, 0);
    chk("rw_wdata_after", rf_data_in, 0);
    chk("rw_err_after", sb_err, 0);
    chk("rw_ptr_ld_wins", ld_ready, 1);
    chk("rw_ptr_alu_loses", alu_ready, 0);
    tick();

    // ---------------- randomized against the reference model ----------------
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit r, av, lv, cv, g_alu, g_ld, fa, fb;
      logic [4:0] aa, la, ca, ra, rb;
      logic [31:0] ad, ldd;
      r  = ($urandom_range(0, 39) == 0);
      av = $urandom_range(0, 1);
      lv = $urandom_range(0, 1);
      cv = ($urandom_range(0, 3) == 0);
      aa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      la = 5'($urandom_range(0, 7));
      ca = 5'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      ad = $urandom;
      ldd = $urandom;
      reset = r;
      drive(av, aa, ad, lv, la, ldd, cv, ca, ra, rb);
      #1;

      if (r) begin
        g_alu = 0; g_ld = 0;
      end else if (av && lv) begin
        g_ld = m_last_alu; g_alu = !m_last_alu;
      end else begin
        g_alu = av; g_ld = lv;
      end
      fa = BYP && m_wr && (m_wa == ra) && (ra != 0);
      fb = BYP && m_wr && (m_wa == rb) && (rb != 0);

      chk("rnd_alu_ready", alu_ready, g_alu);
      chk("rnd_ld_ready", ld_ready, g_ld);
      chk("rnd_hazard", hazard, (m_pend[ra] && !fa) || (m_pend[rb] && !fb));
      chk("rnd_rf_write", rf_write, m_wr);
      if (m_wr) begin
        chk("rnd_rf_addr", rf_write_addr, m_wa);
        chk("rnd_rf_data", rf_data_in, m_wd);
      end
      chk("rnd_pending", pending, model_pend_vec());
      chk("rnd_sb_err", sb_err, m_err);
      chk("rnd_fwd_a", fwd_a_hit, fa);
      chk("rnd_fwd_b", fwd_b_hit, fb);
      chk("rnd_fwd_data", fwd_data, BYP ? m_wd : 32'h0);

      if (r) begin
        model_reset();
      end else begin
        if (cv && ca != 0 && m_pend[ca]) m_err = 1;
        if (m_wr && m_wa != 0 && !m_pend[m_wa]) m_err = 1;
        if (m_wr) m_pend[m_wa] = 0;
        if (cv && ca != 0) m_pend[ca] = 1;
        if (g_alu) begin
          m_wr = (aa != 0); m_wa = aa; m_wd = ad; m_last_alu = 1;
        end else if (g_ld) begin
          m_wr = (la != 0); m_wa = la; m_wd = ldd; m_last_alu = 0;
        end else begin
          m_wr = 0;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
